// File: rtl/cam_frame_writer.sv
// Drains the camera pixel FIFO into fixed-length SDRAM write bursts at linear frame addresses.
// Optional ping-pong frame buffering via `define CAM_FRAME_WRITER_DOUBLE_BUFFER_EN (adds rd_bank).
module cam_frame_writer #(
   parameter int BURST_LEN   = 256,
   parameter int FRAME_WORDS = 307200,
   parameter int ADDR_W      = 24,
   parameter int FRAME_BASE  = 0
) (
   input  logic              clk_100,
   input  logic              rst_n,
   input  logic [9:0]        fifo_count,
   input  logic [15:0]       fifo_dout,
   output logic              fifo_rd_en,
   input  logic              frame_sync,
   output logic              sd_wr_req,
   input  logic              sd_wr_ack,
   output logic [ADDR_W-1:0] sd_wr_addr,
   input  logic              sd_wr_data_req,
   output logic [15:0]       sd_wr_data,
   output logic              frame_done,
   output logic              busy
`ifdef CAM_FRAME_WRITER_DOUBLE_BUFFER_EN
   ,
   output logic              rd_bank
`endif
);

   localparam int CNT_W = $clog2(BURST_LEN) + 1;

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] REQ     = 2'd1;
   localparam logic [1:0] BURST   = 2'd2;
   localparam logic [1:0] ADVANCE = 2'd3;

   localparam logic [ADDR_W-1:0] BASE_A  = ADDR_W'(FRAME_BASE);
   localparam logic [ADDR_W-1:0] FRAME_A = ADDR_W'(FRAME_WORDS);
   localparam logic [ADDR_W-1:0] BURST_A = ADDR_W'(BURST_LEN);
   localparam logic [CNT_W-1:0]  BURST_END = CNT_W'(BURST_LEN);
   localparam logic [10:0]       FILL_MIN  = 11'(BURST_LEN);

   logic [1:0]        state;
   logic [ADDR_W-1:0] word_ptr;
   logic [ADDR_W-1:0] bank_offset;
   logic              sync_pending;
   logic [CNT_W-1:0]  rd_cnt;
   logic              fifo_ok;
   logic              vld_p1;
   logic [15:0]       last_data_p1;

`ifdef CAM_FRAME_WRITER_DOUBLE_BUFFER_EN
   logic wr_bank;
   assign bank_offset = wr_bank ? FRAME_A : '0;
`else
   assign bank_offset = '0;
`endif

   assign fifo_ok    = ({1'b0, fifo_count} >= FILL_MIN);
   assign fifo_rd_en = (state == BURST) && sd_wr_data_req && (rd_cnt < BURST_END);
   assign busy       = (state != IDLE);
   // FIFO data arrives one cycle after the read strobe; outside that cycle the last word is held.
   assign sd_wr_data = vld_p1 ? fifo_dout : last_data_p1;

   always_ff @(posedge clk_100 or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         word_ptr     <= '0;
         sync_pending <= 1'b0;
         rd_cnt       <= '0;
         sd_wr_req    <= 1'b0;
         sd_wr_addr   <= '0;
         frame_done   <= 1'b0;
`ifdef CAM_FRAME_WRITER_DOUBLE_BUFFER_EN
         wr_bank      <= 1'b0;
         rd_bank      <= 1'b0;
`endif
      end else begin
         frame_done <= 1'b0;
         case (state)
            IDLE: begin
               if (sync_pending) begin
                  word_ptr     <= '0;
                  sync_pending <= 1'b0;
               end else if (fifo_ok) begin
                  sd_wr_addr <= BASE_A + bank_offset + word_ptr;
                  sd_wr_req  <= 1'b1;
                  state      <= REQ;
               end
            end
            REQ: begin
               if (sd_wr_ack) begin
                  sd_wr_req <= 1'b0;
                  rd_cnt    <= '0;
                  state     <= BURST;
               end
            end
            BURST: begin
               // The cycle with rd_cnt at BURST_LEN is the one carrying the last data word.
               if (rd_cnt == BURST_END) begin
                  state <= ADVANCE;
               end else if (fifo_rd_en) begin
                  rd_cnt <= rd_cnt + CNT_W'(1);
               end
            end
            ADVANCE: begin
               if (word_ptr + BURST_A == FRAME_A) begin
                  word_ptr   <= '0;
                  frame_done <= 1'b1;
`ifdef CAM_FRAME_WRITER_DOUBLE_BUFFER_EN
                  wr_bank    <= ~wr_bank;
                  rd_bank    <= wr_bank;
`endif
               end else begin
                  word_ptr <= word_ptr + BURST_A;
               end
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
         // A new sync always wins over the IDLE clear so no vsync is ever lost.
         if (frame_sync) sync_pending <= 1'b1;
      end
   end

   // Read-data stage boundary
   always_ff @(posedge clk_100 or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1       <= 1'b0;
         last_data_p1 <= '0;
      end else begin
         vld_p1 <= fifo_rd_en;
         if (vld_p1) last_data_p1 <= fifo_dout;
      end
   end

endmodule

// File: tb/tb_cam_frame_writer.sv
// Directed bench for cam_frame_writer: a frame-level address/data model checked every cycle.
module tb_cam_frame_writer;

   localparam int BL   = 256;
`ifdef CAM_FRAME_WRITER_DOUBLE_BUFFER_EN
   localparam int FW   = 512;
`else
   localparam int FW   = 1024;
`endif
   localparam int AW   = 24;
   localparam int BASE = 0;
   localparam int NB   = 9;

   logic          clk_100 = 1'b0;
   logic          rst_n = 1'b1;
   logic [9:0]    fifo_count;
   logic [15:0]   fifo_dout = '0;
   logic          fifo_rd_en;
   logic          frame_sync = 1'b0;
   logic          sd_wr_req;
   logic          sd_wr_ack = 1'b0;
   logic [AW-1:0] sd_wr_addr;
   logic          sd_wr_data_req = 1'b0;
   logic [15:0]   sd_wr_data;
   logic          frame_done;
   logic          busy;
`ifdef CAM_FRAME_WRITER_DOUBLE_BUFFER_EN
   logic          rd_bank;
`endif

   cam_frame_writer #(
      .BURST_LEN(BL), .FRAME_WORDS(FW), .ADDR_W(AW), .FRAME_BASE(BASE)
   ) dut (
      .clk_100(clk_100), .rst_n(rst_n), .fifo_count(fifo_count), .fifo_dout(fifo_dout),
      .fifo_rd_en(fifo_rd_en), .frame_sync(frame_sync), .sd_wr_req(sd_wr_req),
      .sd_wr_ack(sd_wr_ack), .sd_wr_addr(sd_wr_addr), .sd_wr_data_req(sd_wr_data_req),
      .sd_wr_data(sd_wr_data), .frame_done(frame_done), .busy(busy)
`ifdef CAM_FRAME_WRITER_DOUBLE_BUFFER_EN
      , .rd_bank(rd_bank)
`endif
   );

   always #5 clk_100 = ~clk_100;

   // Pixel FIFO: word k of the stream is mem[k]
   logic [15:0] mem [0:4095];
   int push_idx = 0;
   int pop_idx  = 0;
   assign fifo_count = 10'(((push_idx - pop_idx) > 1023) ? 1023 : (push_idx - pop_idx));
   always @(posedge clk_100) begin
      if (fifo_rd_en === 1'b1) begin
         fifo_dout <= mem[pop_idx];
         pop_idx   <= pop_idx + 1;
      end
   end

   int n_vec  = 0;
   int n_miss = 0;

   // Frame-level model state
   bit            chk_en = 1'b0;
   int            exp_ptr = 0;
   int            exp_bank = 0;
   int            exp_rd_bank = 0;
   int            exp_done = 0;
   int            seen_done = 0;
   bit            sync_flag = 1'b0;
   bit            req_seen = 1'b0;
   logic [AW-1:0] hold_addr = '0;
   bit            burst_open = 1'b0;
   int            pulled = 0;
   int            rd_en_cnt = 0;
   bit            data_due = 1'b0;
   int            exp_pop = 0;
   logic [15:0]   last_word = '0;
   int            addr_log [0:15];
   int            n_addr = 0;
   int            exp_addrs [0:NB-1];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic model_advance();
      if (exp_ptr + BL == FW) begin
         exp_ptr = 0;
         exp_done++;
`ifdef CAM_FRAME_WRITER_DOUBLE_BUFFER_EN
         exp_rd_bank = exp_bank;
         exp_bank    = 1 - exp_bank;
`endif
      end else begin
         exp_ptr = exp_ptr + BL;
      end
   endtask

   task automatic model_reset();
      exp_ptr     = 0;
      exp_bank    = 0;
      exp_rd_bank = 0;
      sync_flag   = 1'b0;
      req_seen    = 1'b0;
      burst_open  = 1'b0;
      pulled      = 0;
      data_due    = 1'b0;
      exp_pop     = pop_idx;
   endtask

   always @(negedge clk_100) begin : cmp
      logic exp_rd;
      int   exp_addr;
      if (chk_en) begin
         if (frame_done === 1'b1) seen_done++;
         if (data_due) begin
            check("wr_data", sd_wr_data, mem[exp_pop]);
            last_word = mem[exp_pop];
            exp_pop++;
            data_due = 1'b0;
         end else if (burst_open && pulled == BL) begin
            check("wr_data_hold", sd_wr_data, last_word);
         end
         exp_rd = sd_wr_data_req && burst_open && (pulled < BL);
         check("fifo_rd_en", fifo_rd_en, exp_rd);
         if (fifo_rd_en === 1'b1) rd_en_cnt++;
         if (exp_rd) begin
            pulled++;
            data_due = 1'b1;
            if (pulled == BL) model_advance();
         end
         if (frame_sync) sync_flag = 1'b1;
         if (sd_wr_req === 1'b1 && !req_seen) begin
            if (sync_flag) begin
               exp_ptr   = 0;
               sync_flag = 1'b0;
            end
            exp_addr = BASE + exp_bank * FW + exp_ptr;
            check("frame_done_count", seen_done, exp_done);
            check("burst_addr", sd_wr_addr, exp_addr);
`ifdef CAM_FRAME_WRITER_DOUBLE_BUFFER_EN
            check("rd_bank", rd_bank, exp_rd_bank);
`endif
            if (n_addr < 16) addr_log[n_addr] = int'(sd_wr_addr);
            n_addr++;
            req_seen  = 1'b1;
            hold_addr = sd_wr_addr;
         end else if (sd_wr_req === 1'b1) begin
            check("addr_hold", sd_wr_addr, hold_addr);
         end
         if (sd_wr_req !== 1'b1) req_seen = 1'b0;
      end
   end

   task automatic tick();
      @(posedge clk_100);
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_fifo_rd_en"}, fifo_rd_en, 0);
      check({tag, "_sd_wr_req"}, sd_wr_req, 0);
      check({tag, "_sd_wr_addr"}, sd_wr_addr, 0);
      check({tag, "_sd_wr_data"}, sd_wr_data, 0);
      check({tag, "_frame_done"}, frame_done, 0);
      check({tag, "_busy"}, busy, 0);
`ifdef CAM_FRAME_WRITER_DOUBLE_BUFFER_EN
      check({tag, "_rd_bank"}, rd_bank, 0);
`endif
   endtask

   task automatic do_abort();
      chk_en = 1'b0;
      sd_wr_data_req = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("abort");
      sd_wr_data_req = 1'b0;
      model_reset();
      repeat (2) @(posedge clk_100);
      #2;
      rst_n = 1'b1;
      tick();
      chk_en = 1'b1;
   endtask

   task automatic run_burst(input int ack_dly, input bit extra, input int sync_at, input int abort_at);
      int t;
      t = 0;
      while (sd_wr_req !== 1'b1 && t < 50) begin
         tick();
         t++;
      end
      if (sd_wr_req !== 1'b1) begin
         check("req_timeout", sd_wr_req, 1);
         return;
      end
      for (int i = 0; i < ack_dly; i++) begin
         check("req_hold", sd_wr_req, 1);
         tick();
      end
      sd_wr_ack = 1'b1;
      tick();
      sd_wr_ack  = 1'b0;
      pulled     = 0;
      rd_en_cnt  = 0;
      burst_open = 1'b1;
      check("busy_in_burst", busy, 1);
      for (int i = 0; i < BL; i++) begin
         if (i == abort_at) begin
            do_abort();
            return;
         end
         sd_wr_data_req = 1'b1;
         if (i == sync_at) frame_sync = 1'b1;
         tick();
         sd_wr_data_req = 1'b0;
         frame_sync     = 1'b0;
         if (i < BL - 1) repeat ($urandom_range(0, 2)) tick();
      end
      if (extra) begin
         sd_wr_data_req = 1'b1;
         tick();
         sd_wr_data_req = 1'b0;
      end
      repeat (5) tick();
      check("rd_en_count", rd_en_cnt, BL);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got %0d vectors, expected completion", n_vec);
      $fatal(1, "watchdog");
   end

   initial begin
`ifdef CAM_FRAME_WRITER_DOUBLE_BUFFER_EN
      exp_addrs = '{0, 256, 512, 768, 0, 256, 512, 768, 0};
`else
      exp_addrs = '{0, 256, 512, 768, 0, 256, 0, 256, 0};
`endif
      for (int i = 0; i < 4096; i++) begin
         if (i < 256) mem[i] = 16'(i);
         else         mem[i] = 16'((i * 40503) ^ 32'h5a5a);
      end

      #1 rst_n = 1'b0;
      #2 check_reset_outputs("reset");
      repeat (3) @(posedge clk_100);
      #2 rst_n = 1'b1;
      tick();
      chk_en = 1'b1;

      // One word short of a burst: no request may appear
      push_idx = push_idx + 255;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("req_below_threshold", sd_wr_req, 0);
      end
      push_idx = push_idx + 1;
      tick();
      check("req_at_threshold", sd_wr_req, 1);
      check("first_addr", sd_wr_addr, 0);
      run_burst(10, 1'b1, -1, -1);

      push_idx = push_idx + 768;
      run_burst(2, 1'b0, -1, -1);
`ifdef CAM_FRAME_WRITER_DOUBLE_BUFFER_EN
      check("rd_bank_after_frame0", rd_bank, 0);
`endif
      run_burst(0, 1'b1, -1, -1);
      run_burst(5, 1'b0, -1, -1);
`ifdef CAM_FRAME_WRITER_DOUBLE_BUFFER_EN
      check("done_after_b4", seen_done, 2);
      check("rd_bank_after_frame1", rd_bank, 1);
`else
      check("done_after_b4", seen_done, 1);
`endif

      push_idx = push_idx + 256;
      run_burst(1, 1'b0, -1, -1);
      push_idx = push_idx + 256;
      run_burst(3, 1'b0, 100, -1);
`ifdef CAM_FRAME_WRITER_DOUBLE_BUFFER_EN
      check("done_after_sync", seen_done, 3);
`else
      check("done_after_sync", seen_done, 1);
`endif
      push_idx = push_idx + 256;
      run_burst(0, 1'b0, -1, -1);
      push_idx = push_idx + 256;
      run_burst(4, 1'b0, -1, 100);
      push_idx = push_idx + 256;
      run_burst(2, 1'b0, -1, -1);

      check("burst_count", n_addr, NB);
      for (int i = 0; i < NB; i++) check($sformatf("addr_seq%0d", i), addr_log[i], exp_addrs[i]);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
